// File: rtl/decoder_3to8_seq.sv
// Registered 3-to-8 decoder: accepts an index over valid/ready, pulses one-hot Y for HOLD_CYCLES, then idles Y for GAP_CYCLES.
// Define DEC3TO8_PARITY_EN to add par_in/err: an accepted index with even parity on {par_in,A} is dropped and flagged.
module decoder_3to8_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       E,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] A,
  output logic [7:0] Y,
  output logic       busy,
  output logic       done
`ifdef DEC3TO8_PARITY_EN
  ,
  input  logic       par_in,
  output logic       err
`endif
);

  localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       y_q, y_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             accept;
  logic             par_ok;

`ifdef DEC3TO8_PARITY_EN
  assign par_ok = ^{par_in, A};
  assign err    = err_q;
`else
  assign par_ok = 1'b1;
`endif

  assign in_ready = (state_q == ST_IDLE) & E;
  assign accept   = in_valid & in_ready;
  assign Y        = y_q;
  assign busy     = (state_q == ST_HOLD) | (state_q == ST_GAP);
  assign done     = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (par_ok) begin
            state_d = ST_HOLD;
            y_d     = 8'h01 << A;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // Dropping E aborts the pulse: Y clears without a done strobe.
        if (!E) begin
          state_d = ST_IDLE;
          y_d     = 8'h00;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
          y_d     = 8'h00;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        y_d     = 8'h00;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      y_q     <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule
